display_sequencer: RTL and testbench

Command-driven bring-up/shutdown sequencer for the VGA pipeline, clocked on system_clock. Decodes MCU command bytes (one-cycle strobes from the message broker) into a timed vga_reset pulse, a settle delay and vga_enable control. It generalises the fixed start-only sequence with parametrised pulse and settle lengths, STOP/RESTART commands, optional vsync-aligned enable/disable with timeout, and status outputs.

---
 rtl/display_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_display_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// display_sequencer: command-driven bring-up/shutdown sequencer for the VGA
// pipeline. Decodes MCU command bytes into a timed vga_reset pulse, a settle
// delay and vga_enable control, with optional vsync-aligned enable/disable.
//
// Command interface: command_valid is a one-cycle strobe with no back-pressure.
// A command is consumed in the cycle it is presented (acted on when the
// sequencer is idle or running) or dropped (when the sequencer is busy).
// Dropped START/STOP/RESTART codes are tallied in rejected_count.
module display_sequencer #(
  parameter int CMD_WIDTH          = 8,
  parameter int CMD_START          = 2,
  parameter int CMD_STOP           = 3,
  parameter int CMD_RESTART        = 4,
  parameter int RESET_PULSE_CYCLES = 1,
  parameter int SETTLE_CYCLES      = 8,
  parameter int ALIGN_TO_FRAME     = 0,
  parameter int VSYNC_ACTIVE_LOW   = 1,
  parameter int FRAME_TIMEOUT      = 1048576,
  parameter int CNT_WIDTH          = 24
) (
  input  logic                 system_clock,
  input  logic                 reset_n,
  input  logic                 command_valid,
  input  logic [CMD_WIDTH-1:0] command,
  input  logic                 vsync,
  output logic                 vga_reset,
  output logic                 vga_enable,
  output logic                 busy,
  output logic [2:0]           state,
  output logic                 timeout_error,
  output logic [7:0]           rejected_count
);

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_RESET_PULSE    = 3'd1,
    ST_SETTLE         = 3'd2,
    ST_WAIT_FRAME_ON  = 3'd3,
    ST_RUNNING        = 3'd4,
    ST_WAIT_FRAME_OFF = 3'd5
  } seq_state_t;

  localparam logic [CMD_WIDTH-1:0] CODE_START   = CMD_WIDTH'(CMD_START);
  localparam logic [CMD_WIDTH-1:0] CODE_STOP    = CMD_WIDTH'(CMD_STOP);
  localparam logic [CMD_WIDTH-1:0] CODE_RESTART = CMD_WIDTH'(CMD_RESTART);

  // Terminal counts: the counter starts at 0 on state entry, so a phase of
  // N cycles ends when the counter shows N-1.
  localparam logic [CNT_WIDTH-1:0] PULSE_LAST   = CNT_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(FRAME_TIMEOUT - 1);

  // Level vsync rests at between frames; the synchroniser powers up here so
  // reset itself never looks like a frame edge.
  localparam logic VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Where the sequence goes once settling is over, and straight after the
  // reset pulse when there is no settle phase at all.
  localparam seq_state_t POST_SETTLE = (ALIGN_TO_FRAME != 0) ? ST_WAIT_FRAME_ON : ST_RUNNING;
  localparam seq_state_t POST_PULSE  = (SETTLE_CYCLES == 0) ? POST_SETTLE : ST_SETTLE;
  localparam seq_state_t STOP_TARGET = (ALIGN_TO_FRAME != 0) ? ST_WAIT_FRAME_OFF : ST_IDLE;

  seq_state_t           state_q;
  seq_state_t           state_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  logic vsync_meta;
  logic vsync_sync;
  logic vsync_prev;
  logic vsync_edge;

  logic cmd_start;
  logic cmd_stop;
  logic cmd_restart;
  logic cmd_known;
  logic busy_now;
  logic timed_state;
  logic terr_set;
  logic terr_clr;
  logic reject;

  // vsync arrives from the vga_clock domain: two flops to resolve
  // metastability, a third to remember the previous synchronised level.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_meta <= VSYNC_IDLE;
      vsync_sync <= VSYNC_IDLE;
      vsync_prev <= VSYNC_IDLE;
    end else begin
      vsync_meta <= vsync;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
    end
  end

  // Frame start = inactive-to-active transition of the synchronised vsync.
  assign vsync_edge = (vsync_sync != VSYNC_IDLE) && (vsync_prev == VSYNC_IDLE);

  assign cmd_start   = command_valid && (command == CODE_START);
  assign cmd_stop    = command_valid && (command == CODE_STOP);
  assign cmd_restart = command_valid && (command == CODE_RESTART);
  assign cmd_known   = cmd_start || cmd_stop || cmd_restart;

  assign busy_now    = (state_q == ST_RESET_PULSE) || (state_q == ST_SETTLE) ||
                       (state_q == ST_WAIT_FRAME_ON) || (state_q == ST_WAIT_FRAME_OFF);
  assign timed_state = busy_now;

  // A known command is dropped whenever the pre-transition state is busy,
  // even if that state is exiting in the same cycle.
  assign reject = busy_now && cmd_known;

  // Next-state logic: timed phases end on their terminal count, the frame
  // waits end on a vsync edge (which beats a simultaneous timeout), and
  // commands are only looked at in IDLE and RUNNING.
  always_comb begin
    state_d  = state_q;
    terr_set = 1'b0;
    terr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d  = ST_RESET_PULSE;
          terr_clr = 1'b1;
        end
      end
      ST_RESET_PULSE: begin
        if (count_q == PULSE_LAST) state_d = POST_PULSE;
      end
      ST_SETTLE: begin
        if (count_q == SETTLE_LAST) state_d = POST_SETTLE;
      end
      ST_WAIT_FRAME_ON: begin
        if (vsync_edge) begin
          state_d = ST_RUNNING;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d  = ST_IDLE;
          terr_set = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (cmd_stop) begin
          state_d = STOP_TARGET;
        end else if (cmd_restart) begin
          state_d = ST_RESET_PULSE;
        end
      end
      ST_WAIT_FRAME_OFF: begin
        if (vsync_edge) begin
          state_d = ST_IDLE;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d  = ST_IDLE;
          terr_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase counter: cleared on every state change, advances only in timed
  // states, so it never runs free in IDLE or RUNNING.
  always_comb begin
    count_d = '0;
    if ((state_d == state_q) && timed_state) count_d = count_q + CNT_WIDTH'(1);
  end

  // State register and phase counter.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Registered control outputs, decoded from the state being entered so they
  // line up with the state output in the same cycle.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_reset  <= 1'b0;
      vga_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vga_reset  <= (state_d == ST_RESET_PULSE);
      vga_enable <= (state_d == ST_RUNNING) || (state_d == ST_WAIT_FRAME_OFF);
      busy       <= (state_d == ST_RESET_PULSE) || (state_d == ST_SETTLE) ||
                    (state_d == ST_WAIT_FRAME_ON) || (state_d == ST_WAIT_FRAME_OFF);
    end
  end

  // Sticky timeout flag: set by a missed frame edge, cleared by an accepted START.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_error <= 1'b0;
    end else if (terr_set) begin
      timeout_error <= 1'b1;
    end else if (terr_clr) begin
      timeout_error <= 1'b0;
    end
  end

  // Saturating tally of known commands dropped while busy.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      rejected_count <= 8'd0;
    end else if (reject && (rejected_count != 8'hFF)) begin
      rejected_count <= rejected_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: four differently-parameterised sequencers share one
// stimulus stream; a timestamp-based reference model predicts every output
// each cycle, and directed sequences pin down the documented timings.
module tb_display_sequencer;

  localparam int N_DUT = 4;
  // d0 defaults, d1 frame-aligned with short timeout, d2 long pulse / no settle /
  // active-high vsync, d3 long settle for rejection saturation.
  localparam int RP_C [N_DUT] = '{1, 1, 3, 1};
  localparam int SC_C [N_DUT] = '{8, 8, 0, 400};
  localparam int AL_C [N_DUT] = '{0, 1, 1, 0};
  localparam int VL_C [N_DUT] = '{1, 1, 0, 1};
  localparam int FT_C [N_DUT] = '{1048576, 16, 40, 1048576};

  localparam logic [7:0] START   = 8'd2;
  localparam logic [7:0] STOP    = 8'd3;
  localparam logic [7:0] RESTART = 8'd4;
  localparam logic [7:0] BOGUS   = 8'h7F;

  // ---------------- clock / reset / inputs ----------------
  logic       system_clock  = 1'b0;
  logic       reset_n       = 1'b1;
  logic       command_valid = 1'b0;
  logic [7:0] command       = 8'd0;
  logic       vsync         = 1'b1;

  always #5 system_clock = ~system_clock;

  logic       dut_reset  [N_DUT];
  logic       dut_enable [N_DUT];
  logic       dut_busy   [N_DUT];
  logic [2:0] dut_state  [N_DUT];
  logic       dut_terr   [N_DUT];
  logic [7:0] dut_rej    [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    display_sequencer #(
      .CMD_WIDTH(8),
      .CMD_START(2),
      .CMD_STOP(3),
      .CMD_RESTART(4),
      .RESET_PULSE_CYCLES(RP_C[g]),
      .SETTLE_CYCLES(SC_C[g]),
      .ALIGN_TO_FRAME(AL_C[g]),
      .VSYNC_ACTIVE_LOW(VL_C[g]),
      .FRAME_TIMEOUT(FT_C[g]),
      .CNT_WIDTH(24)
    ) u_dut (
      .system_clock(system_clock),
      .reset_n(reset_n),
      .command_valid(command_valid),
      .command(command),
      .vsync(vsync),
      .vga_reset(dut_reset[g]),
      .vga_enable(dut_enable[g]),
      .busy(dut_busy[g]),
      .state(dut_state[g]),
      .timeout_error(dut_terr[g]),
      .rejected_count(dut_rej[g])
    );
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each sequencer is described by its phase code, the edge number at which the
  // phase was entered, and the recent history of sampled vsync activity.
  int edge_n = 0;
  int ph    [N_DUT];
  int t_in  [N_DUT];
  int rej   [N_DUT];
  bit terr  [N_DUT];
  bit h0    [N_DUT];
  bit h1    [N_DUT];
  bit h2    [N_DUT];
  bit h3    [N_DUT];

  function automatic bit is_busy(int p);
    return (p == 1) || (p == 2) || (p == 3) || (p == 5);
  endfunction

  function automatic void enter(int i, int p);
    ph[i]   = p;
    t_in[i] = edge_n;
  endfunction

  function automatic void model_reset(int i);
    ph[i] = 0; t_in[i] = 0; rej[i] = 0; terr[i] = 1'b0;
    h0[i] = 1'b0; h1[i] = 1'b0; h2[i] = 1'b0; h3[i] = 1'b0;
  endfunction

  function automatic void model_step(int i);
    int el;
    int after_settle;
    bit edge_seen;
    bit busy_pre;
    bit known;
    // hN = "vsync was active when sampled N edges ago"; a frame edge acts
    // three edges after the pin change.
    h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = h0[i];
    h0[i] = (VL_C[i] != 0) ? !vsync : vsync;
    edge_seen    = h2[i] && !h3[i];
    el           = edge_n - t_in[i];
    busy_pre     = is_busy(ph[i]);
    known        = command_valid && ((command == START) || (command == STOP) || (command == RESTART));
    after_settle = (AL_C[i] != 0) ? 3 : 4;
    case (ph[i])
      0: if (command_valid && command == START) begin enter(i, 1); terr[i] = 1'b0; end
      1: if (el == RP_C[i]) enter(i, (SC_C[i] == 0) ? after_settle : 2);
      2: if (el == SC_C[i]) enter(i, after_settle);
      3: if (edge_seen) enter(i, 4);
         else if (el == FT_C[i]) begin terr[i] = 1'b1; enter(i, 0); end
      4: if (command_valid && command == STOP) enter(i, (AL_C[i] != 0) ? 5 : 0);
         else if (command_valid && command == RESTART) enter(i, 1);
      5: if (edge_seen) enter(i, 0);
         else if (el == FT_C[i]) begin terr[i] = 1'b1; enter(i, 0); end
      default: enter(i, 0);
    endcase
    if (busy_pre && known && rej[i] < 255) rej[i]++;
  endfunction

  // Model advances on the same edges as the DUTs and clears on async reset.
  always @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_n = 0;
      for (int i = 0; i < N_DUT; i++) model_reset(i);
    end else begin
      edge_n++;
      for (int i = 0; i < N_DUT; i++) model_step(i);
    end
  end

  // Scoreboard: every DUT output against the model, sampled on the falling edge.
  bit mon_en = 1'b0;
  always @(negedge system_clock) begin
    if (mon_en) begin
      for (int i = 0; i < N_DUT; i++) begin
        check_eq($sformatf("d%0d.state", i),     32'(dut_state[i]),  32'(ph[i]));
        check_eq($sformatf("d%0d.vga_reset", i), 32'(dut_reset[i]),  32'(ph[i] == 1));
        check_eq($sformatf("d%0d.vga_enable", i),32'(dut_enable[i]), 32'((ph[i] == 4) || (ph[i] == 5)));
        check_eq($sformatf("d%0d.busy", i),      32'(dut_busy[i]),   32'(is_busy(ph[i])));
        check_eq($sformatf("d%0d.timeout", i),   32'(dut_terr[i]),   32'(terr[i]));
        check_eq($sformatf("d%0d.rejected", i),  32'(dut_rej[i]),    32'(rej[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; leaves the bench on a falling edge with reset released.
  task automatic do_reset();
    #2;
    reset_n       = 1'b0;
    command_valid = 1'b0;
    vsync         = 1'b1;
    repeat (2) @(negedge system_clock);
    reset_n = 1'b1;
  endtask

  // Presents inputs for one cycle; returns on the next falling edge, where the
  // outputs reflect that cycle's command.
  task automatic step(input logic cv, input logic [7:0] cmd);
    command_valid = cv;
    command       = cmd;
    @(negedge system_clock);
    command_valid = 1'b0;
  endtask

  logic [5:0] exp_q [$];
  logic [5:0] exp_v;

  initial begin
    // -------- defaults: START timing --------
    do_reset();
    mon_en = 1'b1;
    check_eq("rst.state",   32'(dut_state[0]),  32'd0);
    check_eq("rst.enable",  32'(dut_enable[0]), 32'd0);
    check_eq("rst.rejcnt",  32'(dut_rej[0]),    32'd0);
    // {busy, enable, reset, state} for cycles 1..11
    for (int c = 1; c <= 11; c++) begin
      if (c == 1)      exp_q.push_back({1'b1, 1'b0, 1'b1, 3'd1});
      else if (c <= 9) exp_q.push_back({1'b1, 1'b0, 1'b0, 3'd2});
      else             exp_q.push_back({1'b0, 1'b1, 1'b0, 3'd4});
    end
    step(1'b1, START);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check_eq("start_seq", 32'({dut_busy[0], dut_enable[0], dut_reset[0], dut_state[0]}), 32'(exp_v));
      if (exp_q.size() > 0) step(1'b0, 8'd0);
    end
    // -------- RESTART while running (T = 11) --------
    step(1'b1, RESTART);
    check_eq("restart.state",  32'(dut_state[0]),  32'd1);
    check_eq("restart.reset",  32'(dut_reset[0]),  32'd1);
    check_eq("restart.enable", 32'(dut_enable[0]), 32'd0);
    repeat (8) step(1'b0, 8'd0);
    check_eq("restart.en_t9",  32'(dut_enable[0]), 32'd0);
    step(1'b0, 8'd0);
    check_eq("restart.en_t10", 32'(dut_enable[0]), 32'd1);

    // -------- frame-aligned enable and disable --------
    do_reset();
    step(1'b1, START);
    repeat (19) step(1'b0, 8'd0);
    check_eq("align.wait_on", 32'(dut_state[1]), 32'd3);
    vsync = 1'b0;
    repeat (2) step(1'b0, 8'd0);
    check_eq("align.en_c22", 32'(dut_enable[1]), 32'd0);
    step(1'b0, 8'd0);
    check_eq("align.en_c23", 32'(dut_enable[1]), 32'd1);
    check_eq("align.run",    32'(dut_state[1]),  32'd4);
    step(1'b1, STOP);
    check_eq("align.wait_off", 32'(dut_state[1]),  32'd5);
    check_eq("align.en_hold",  32'(dut_enable[1]), 32'd1);
    vsync = 1'b1;
    repeat (4) step(1'b0, 8'd0);
    vsync = 1'b0;
    repeat (2) step(1'b0, 8'd0);
    check_eq("align.en_c30", 32'(dut_enable[1]), 32'd1);
    step(1'b0, 8'd0);
    check_eq("align.en_c31", 32'(dut_enable[1]), 32'd0);
    check_eq("align.idle",   32'(dut_state[1]),  32'd0);

    // -------- frame timeout --------
    do_reset();
    step(1'b1, START);
    repeat (24) step(1'b0, 8'd0);
    check_eq("tmo.c25_state", 32'(dut_state[1]), 32'd3);
    check_eq("tmo.c25_flag",  32'(dut_terr[1]),  32'd0);
    step(1'b0, 8'd0);
    check_eq("tmo.c26_state", 32'(dut_state[1]),  32'd0);
    check_eq("tmo.c26_flag",  32'(dut_terr[1]),   32'd1);
    check_eq("tmo.c26_en",    32'(dut_enable[1]), 32'd0);
    step(1'b1, START);
    check_eq("tmo.clear",     32'(dut_terr[1]),  32'd0);
    check_eq("tmo.restart",   32'(dut_state[1]), 32'd1);
    check_eq("tmo.run_start_ignored", 32'(dut_rej[0]), 32'd0);

    // -------- rejection counting and saturation --------
    do_reset();
    step(1'b1, START);
    repeat (5) step(1'b1, BOGUS);
    check_eq("rej.bogus", 32'(dut_rej[3]), 32'd0);
    repeat (10) step(1'b1, START);
    check_eq("rej.ten",     32'(dut_rej[3]), 32'd10);
    check_eq("rej.d0_busy", 32'(dut_rej[0]), 32'd4);
    repeat (290) step(1'b1, START);
    check_eq("rej.sat",      32'(dut_rej[3]),   32'd255);
    check_eq("rej.d3_state", 32'(dut_state[3]), 32'd2);
    check_eq("rej.d0_final", 32'(dut_rej[0]),   32'd4);

    // -------- asynchronous reset mid pulse --------
    do_reset();
    step(1'b1, START);
    step(1'b0, 8'd0);
    check_eq("arst.pre_reset", 32'(dut_reset[2]), 32'd1);
    check_eq("arst.pre_state", 32'(dut_state[2]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst.reset", 32'(dut_reset[2]), 32'd0);
    check_eq("arst.busy",  32'(dut_busy[2]),  32'd0);
    check_eq("arst.state", 32'(dut_state[2]), 32'd0);
    @(negedge system_clock);
    reset_n = 1'b1;

    // -------- randomized traffic --------
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      if (r <= 2)      c = START;
      else if (r <= 4) c = STOP;
      else if (r <= 6) c = RESTART;
      else if (r == 7) c = BOGUS;
      else             c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge system_clock);
        reset_n = 1'b1;
      end else begin
        step($urandom_range(0, 99) < 35, c);
      end
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
